int_to_fp: RTL

Multi-cycle 32-bit integer to IEEE 754 single-precision encoder. It produces the operand format consumed by the `fpu` datapath from integer sources such as counters, ADC samples and register-file values. One conversion is in flight at a time. Normalisation is iterative, one bit per cycle, behind valid/ready handshakes on both sides.

---
 rtl/int_to_fp.sv | 109 ++++++++++
 1 files changed

// File: rtl/int_to_fp.sv
// Iterative int32/uint32 to binary32 converter, one normalisation shift per cycle.
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module int_to_fp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] data_q;
  logic        signed_q;
  logic [31:0] mag;
  logic [7:0]  expo;
  logic        sign;

  logic        abs_sign;
  logic [31:0] abs_mag;
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [23:0] frac_sum;
  logic [7:0]  expo_out;

  always_comb begin
    abs_sign = signed_q & data_q[31];
    abs_mag  = abs_sign ? (~data_q + 32'd1) : data_q;
    frac     = mag[30:8];
    guard    = mag[7];
    sticky   = |mag[6:0];
`ifdef ROUND_NEAREST_EN
    round_up = guard & (sticky | frac[0]);
`else
    round_up = 1'b0;
`endif
    // A carry out of the fraction leaves frac_sum[22:0] all zero, so only the exponent needs fixing.
    frac_sum = {1'b0, frac} + {23'd0, round_up};
    expo_out = expo + {7'd0, frac_sum[23]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ABS;
      ABS:     state_next = (abs_mag == '0) ? DONE : NORM;
      NORM:    if (mag[31]) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      signed_q    <= 1'b0;
      mag         <= '0;
      expo        <= '0;
      sign        <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            signed_q <= in_signed;
          end
        end
        ABS: begin
          sign <= abs_sign;
          mag  <= abs_mag;
          expo <= 8'd158;
          if (abs_mag == '0) begin
            out_data    <= '0;
            out_inexact <= 1'b0;
          end
        end
        NORM: begin
          if (!mag[31]) begin
            mag  <= {mag[30:0], 1'b0};
            expo <= expo - 8'd1;
          end
        end
        ROUND: begin
          out_data    <= {sign, expo_out, frac_sum[22:0]};
          out_inexact <= guard | sticky;
        end
        default: ;
      endcase
    end
  end

endmodule
